clint_timer_unit: RTL and testbench



---
 rtl/clint_pkg.sv | 29 ++
 rtl/clint_mtime_cnt.sv | 41 ++++
 rtl/clint_timer_unit.sv | 116 +++++++++++
 tb/tb_clint_timer_unit.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// bus FSM states and the byte-strobe merge used by every writable register.
package clint_pkg;

   localparam int CPU_WIDTH = 64;

   localparam logic [15:0] MSIP_OFF     = 16'h0000;
   localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
   localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

   typedef enum logic {
      IDLE,
      RESP
   } clint_state_t;

   function automatic logic [CPU_WIDTH-1:0] wstrb_merge(
      input logic [CPU_WIDTH-1:0] old,
      input logic [CPU_WIDTH-1:0] wdata,
      input logic [7:0]           wstrb
   );
      logic [CPU_WIDTH-1:0] merged;
      merged = old;
      for (int i = 0; i < 8; i++) begin
         if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/clint_mtime_cnt.sv
// Free-running mtime counter with prescaler, bus load port and the registered
// mtime >= mtimecmp comparison that drives the timer interrupt.
module clint_mtime_cnt
   import clint_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [CPU_WIDTH-1:0] load_data,
   input  logic [CPU_WIDTH-1:0] mtimecmp,
   output logic [CPU_WIDTH-1:0] mtime,
   output logic                 mtime_int
);

   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

   logic [15:0] prescale;

   // A bus load restarts the tick period so the written value is held a full period.
   always_ff @(posedge clk) begin
      if (reset) begin
         prescale  <= '0;
         mtime     <= '0;
         mtime_int <= 1'b0;
      end else begin
         mtime_int <= (mtime >= mtimecmp);
         if (load) begin
            mtime    <= load_data;
            prescale <= '0;
         end else if (prescale == TICK_LAST) begin
            prescale <= '0;
            mtime    <= mtime + 64'd1;
         end else begin
            prescale <= prescale + 16'd1;
         end
      end
   end

endmodule

// File: rtl/clint_timer_unit.sv
// CLINT MMIO slave: single-outstanding request/response bus FSM, address
// decode, mtimecmp and msip registers around the mtime counter.
module clint_timer_unit
   import clint_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_0200_0000,
   parameter int unsigned TICK_DIV     = 1,
   parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_wen,
   input  logic [CPU_WIDTH-1:0] req_addr,
   input  logic [CPU_WIDTH-1:0] req_wdata,
   input  logic [7:0]           req_wstrb,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [CPU_WIDTH-1:0] rsp_rdata,
   output logic                 rsp_err,
   output logic                 mtime_int,
   output logic                 msip_int
);

   clint_state_t         state;
   logic [CPU_WIDTH-1:0] mtimecmp;
   logic                 msip;
   logic [CPU_WIDTH-1:0] mtime;

   logic                 hit_base;
   logic                 aligned;
   logic [15:0]          offset;
   logic                 sel_msip;
   logic                 sel_cmp;
   logic                 sel_time;
   logic                 dec_err;
   logic                 accept;
   logic                 mtime_load;
   logic [CPU_WIDTH-1:0] rd_data;

   assign hit_base = (req_addr[63:16] == BASE_ADDR[63:16]);
   assign aligned  = (req_addr[2:0] == 3'b000);
   assign offset   = req_addr[15:0];
   assign sel_msip = hit_base && aligned && (offset == MSIP_OFF);
   assign sel_cmp  = hit_base && aligned && (offset == MTIMECMP_OFF);
   assign sel_time = hit_base && aligned && (offset == MTIME_OFF);
   assign dec_err  = !(sel_msip || sel_cmp || sel_time);

   assign accept     = req_valid && req_ready;
   assign mtime_load = accept && req_wen && sel_time;

   // Unmapped offsets fall through to zero so error responses carry no data.
   always_comb begin
      rd_data = '0;
      if (sel_msip)      rd_data = {{(CPU_WIDTH-1){1'b0}}, msip};
      else if (sel_cmp)  rd_data = mtimecmp;
      else if (sel_time) rd_data = mtime;
   end

   clint_mtime_cnt #(
      .TICK_DIV (TICK_DIV)
   ) u_mtime_cnt (
      .clk       (clk),
      .reset     (reset),
      .load      (mtime_load),
      .load_data (wstrb_merge(mtime, req_wdata, req_wstrb)),
      .mtimecmp  (mtimecmp),
      .mtime     (mtime),
      .mtime_int (mtime_int)
   );

   // Response fields are captured at acceptance and held until the master takes them.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mtimecmp  <= MTIMECMP_RST;
         msip      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= RESP;
                  req_ready <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= req_wen ? '0 : rd_data;
                  rsp_err   <= dec_err;
                  if (req_wen && sel_cmp) mtimecmp <= wstrb_merge(mtimecmp, req_wdata, req_wstrb);
                  if (req_wen && sel_msip && req_wstrb[0]) msip <= req_wdata[0];
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign msip_int = msip;

endmodule

// File: tb/tb_clint_timer_unit.sv
// Self-checking bench: two CLINT instances (TICK_DIV 1 and 4) share one bus and
// are compared every cycle against a cycle-count based reference model.
module tb_clint_timer_unit;

   localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
   localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_wen;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        rsp_ready;

   logic [1:0]  req_ready_s;
   logic [1:0]  rsp_valid_s;
   logic [1:0]  rsp_err_s;
   logic [1:0]  mtime_int_s;
   logic [1:0]  msip_int_s;
   logic [63:0] rsp_rdata_s [2];

   clint_timer_unit #(.BASE_ADDR(BASE), .TICK_DIV(1), .MTIMECMP_RST(ALL1)) dut_div1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready_s[0]), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_s[0]),
      .rsp_err(rsp_err_s[0]), .mtime_int(mtime_int_s[0]), .msip_int(msip_int_s[0])
   );

   clint_timer_unit #(.BASE_ADDR(BASE), .TICK_DIV(4), .MTIMECMP_RST(ALL1)) dut_div4 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready_s[1]), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_s[1]),
      .rsp_err(rsp_err_s[1]), .mtime_int(mtime_int_s[1]), .msip_int(msip_int_s[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // mtime is modelled as loadVal + elapsed edges / divisor since the last load or reset
   longint unsigned divs [2] = '{64'd1, 64'd4};
   longint unsigned edgeN = 0;
   logic [63:0]     loadVal [2];
   longint unsigned loadEdge [2];
   logic [63:0]     mCmp;
   logic            mMsip;
   logic            mBusy;
   logic            mErr;
   logic [63:0]     mRd [2];
   logic            mInt [2];
   logic            modelValid = 1'b0;

   int checks = 0;
   int errors = 0;

   function automatic logic [63:0] mtimeAt(input int k, input longint unsigned n);
      return loadVal[k] + 64'((n - loadEdge[k]) / divs[k]);
   endfunction

   function automatic logic [63:0] mergeBytes(input logic [63:0] oldv, input logic [63:0] wv,
                                              input logic [7:0] st);
      logic [63:0] mask;
      mask = '0;
      for (int i = 0; i < 8; i++) begin
         if (st[i]) mask = mask | (64'hFF << (8 * i));
      end
      return (oldv & ~mask) | (wv & mask);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic stepModel();
      longint unsigned prevEdge;
      logic [15:0] off;
      logic        known;
      logic [63:0] cur [2];
      logic        nextInt [2];
      prevEdge = edgeN;
      edgeN++;
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            loadVal[k]  = '0;
            loadEdge[k] = edgeN;
            mInt[k]     = 1'b0;
            mRd[k]      = '0;
         end
         mCmp       = ALL1;
         mMsip      = 1'b0;
         mBusy      = 1'b0;
         mErr       = 1'b0;
         modelValid = 1'b1;
         return;
      end
      for (int k = 0; k < 2; k++) begin
         cur[k]     = mtimeAt(k, prevEdge);
         nextInt[k] = (cur[k] >= mCmp);
      end
      if (mBusy) begin
         if (rsp_ready) mBusy = 1'b0;
      end else if (req_valid) begin
         off   = req_addr[15:0];
         known = ((req_addr >> 16) == (BASE >> 16)) && ((req_addr % 8) == 0) &&
                 (off == 16'h0000 || off == 16'h4000 || off == 16'hBFF8);
         mBusy = 1'b1;
         mErr  = !known;
         for (int k = 0; k < 2; k++) begin
            mRd[k] = '0;
            if (known && !req_wen)
               mRd[k] = (off == 16'h0000) ? {63'd0, mMsip} : (off == 16'h4000) ? mCmp : cur[k];
         end
         if (known && req_wen) begin
            if (off == 16'h0000 && req_wstrb[0]) mMsip = req_wdata[0];
            if (off == 16'h4000) mCmp = mergeBytes(mCmp, req_wdata, req_wstrb);
            if (off == 16'hBFF8) begin
               for (int k = 0; k < 2; k++) begin
                  loadVal[k]  = mergeBytes(cur[k], req_wdata, req_wstrb);
                  loadEdge[k] = edgeN;
               end
            end
         end
      end
      for (int k = 0; k < 2; k++) mInt[k] = nextInt[k];
   endtask

   task automatic checkAll();
      if (!modelValid) return;
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("req_ready%0d", k), 64'(req_ready_s[k]), 64'(!mBusy));
         checkOutput($sformatf("rsp_valid%0d", k), 64'(rsp_valid_s[k]), 64'(mBusy));
         checkOutput($sformatf("mtime_int%0d", k), 64'(mtime_int_s[k]), 64'(mInt[k]));
         checkOutput($sformatf("msip_int%0d", k), 64'(msip_int_s[k]), 64'(mMsip));
         if (mBusy) begin
            checkOutput($sformatf("rsp_rdata%0d", k), rsp_rdata_s[k], mRd[k]);
            checkOutput($sformatf("rsp_err%0d", k), 64'(rsp_err_s[k]), 64'(mErr));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      stepModel();
      #1;
      checkAll();
   endtask

   task automatic applyStimulus(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [7:0] strb, input int delay,
                                output logic [63:0] rd0, output logic [63:0] rd1,
                                output logic err0, output logic [1:0] intAcc,
                                output longint unsigned accEdge);
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = strb;
      tick();
      accEdge   = edgeN;
      rd0       = rsp_rdata_s[0];
      rd1       = rsp_rdata_s[1];
      err0      = rsp_err_s[0];
      intAcc    = mtime_int_s;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      repeat (delay) tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [63:0]     rd0, rd1, wd;
      logic            err0;
      logic [1:0]      intAcc;
      longint unsigned accEdge, rstEdge, loadEdgeW;
      int              guard, cls, dly;
      logic [63:0]     addr;

      reset     = 1'b1;
      req_valid = 1'b0;
      req_wen   = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      rsp_ready = 1'b0;

      $display("[TB] reset and reset-value reads");
      doReset();
      applyStimulus(1'b0, BASE + 64'h4000, '0, 8'hFF, 0, rd0, rd1, err0, intAcc, accEdge);
      checkOutput("rst_mtimecmp", rd0, 64'hFFFF_FFFF_FFFF_FFFF);
      doReset();
      applyStimulus(1'b0, BASE + 64'hBFF8, '0, 8'hFF, 0, rd0, rd1, err0, intAcc, accEdge);
      checkOutput("rst_mtime_div1", rd0, 64'h0);
      checkOutput("rst_mtime_div4", rd1, 64'h0);

      $display("[TB] compare rise and fall");
      doReset();
      rstEdge = edgeN;
      applyStimulus(1'b1, BASE + 64'h4000, 64'h20, 8'hFF, 0, rd0, rd1, err0, intAcc, accEdge);
      guard = 0;
      while (mtime_int_s[0] !== 1'b1 && guard < 100) begin
         tick();
         guard++;
      end
      checkOutput("cmp_rise_edge", 64'(edgeN - rstEdge), 64'd33);
      applyStimulus(1'b1, BASE + 64'h4000, ALL1, 8'hFF, 0, rd0, rd1, err0, intAcc, accEdge);
      checkOutput("cmp_hold_at_write", 64'(intAcc[0]), 64'd1);
      checkOutput("cmp_drop_after_write", 64'(mtime_int_s[0]), 64'd0);

      $display("[TB] response backpressure");
      req_valid = 1'b1;
      req_wen   = 1'b0;
      req_addr  = BASE + 64'hBFF8;
      req_wstrb = 8'hFF;
      tick();
      req_wen   = 1'b1;
      req_addr  = BASE + 64'h4000;
      req_wdata = 64'h0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("bp_rsp_valid", 64'(rsp_valid_s[0]), 64'd1);
         checkOutput("bp_req_ready", 64'(req_ready_s[0]), 64'd0);
         checkOutput("bp_rdata_held", rsp_rdata_s[0], mRd[0]);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("bp_idle_ready", 64'(req_ready_s[0]), 64'd1);
      checkOutput("bp_idle_valid", 64'(rsp_valid_s[0]), 64'd0);
      applyStimulus(1'b0, BASE + 64'h4000, '0, 8'hFF, 0, rd0, rd1, err0, intAcc, accEdge);
      checkOutput("bp_no_second_accept", rd0, ALL1);

      $display("[TB] byte strobes");
      doReset();
      applyStimulus(1'b1, BASE + 64'h4000, 64'h0000_0000_DEAD_BEEF, 8'h0F, 1, rd0, rd1, err0, intAcc, accEdge);
      applyStimulus(1'b0, BASE + 64'h4000, '0, 8'hFF, 0, rd0, rd1, err0, intAcc, accEdge);
      checkOutput("strobe_merge", rd0, 64'hFFFF_FFFF_DEAD_BEEF);

      $display("[TB] wrap and write precedence");
      doReset();
      applyStimulus(1'b1, BASE + 64'h4000, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, rd0, rd1, err0, intAcc, accEdge);
      applyStimulus(1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, rd0, rd1, err0, intAcc, loadEdgeW);
      applyStimulus(1'b0, BASE + 64'hBFF8, '0, 8'hFF, 0, rd0, rd1, err0, intAcc, accEdge);
      checkOutput("wrap_load_div4", rd1, 64'hFFFF_FFFF_FFFF_FFFE);
      checkOutput("wrap_load_div1", rd0, 64'hFFFF_FFFF_FFFF_FFFF);
      while (edgeN < loadEdgeW + 9) begin
         tick();
         if (edgeN == loadEdgeW + 8) checkOutput("wrap_int_before", 64'(mtime_int_s[1]), 64'd1);
         if (edgeN == loadEdgeW + 9) checkOutput("wrap_int_after", 64'(mtime_int_s[1]), 64'd0);
      end
      applyStimulus(1'b0, BASE + 64'hBFF8, '0, 8'hFF, 0, rd0, rd1, err0, intAcc, accEdge);
      checkOutput("wrap_mtime_zero", rd1, 64'h0);

      $display("[TB] errors and msip");
      applyStimulus(1'b1, BASE + 64'h1000, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0, rd0, rd1, err0, intAcc, accEdge);
      checkOutput("err_unmapped", 64'(err0), 64'd1);
      checkOutput("err_unmapped_rdata", rd0, 64'h0);
      applyStimulus(1'b0, BASE + 64'h4004, '0, 8'hFF, 0, rd0, rd1, err0, intAcc, accEdge);
      checkOutput("err_misaligned", 64'(err0), 64'd1);
      applyStimulus(1'b1, BASE, 64'h3, 8'hFF, 0, rd0, rd1, err0, intAcc, accEdge);
      checkOutput("msip_int_set", 64'(msip_int_s[0]), 64'd1);
      applyStimulus(1'b0, BASE, '0, 8'hFF, 0, rd0, rd1, err0, intAcc, accEdge);
      checkOutput("msip_readback", rd0, 64'h1);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 200; n++) begin
         cls = $urandom_range(0, 5);
         wd  = {$urandom, $urandom};
         case (cls)
            0: addr = BASE;
            1: begin
               addr = BASE + 64'h4000;
               if ($urandom_range(0, 1) == 1) wd = 64'($urandom_range(0, 300));
            end
            2: begin
               addr = BASE + 64'hBFF8;
               if ($urandom_range(0, 1) == 1) wd = ALL1 - 64'($urandom_range(0, 20));
            end
            3: addr = BASE + 64'({$urandom_range(0, 8191), 3'b000});
            4: addr = BASE + 64'h4000 + 64'($urandom_range(1, 7));
            default: addr = {$urandom, $urandom};
         endcase
         dly = $urandom_range(0, 3);
         if ($urandom_range(0, 19) == 0) begin
            req_valid = 1'b1;
            req_wen   = 1'($urandom);
            req_addr  = addr;
            req_wdata = wd;
            req_wstrb = 8'($urandom);
            tick();
            req_valid = 1'b0;
            reset     = 1'b1;
            tick();
            reset     = 1'b0;
            checkOutput("rst_mid_rsp_valid", 64'(rsp_valid_s[0]), 64'd0);
         end else begin
            applyStimulus(1'($urandom), addr, wd, 8'($urandom), dly, rd0, rd1, err0, intAcc, accEdge);
         end
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
